// File: rtl/dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dff_bank_arbiter
//  Purpose  : Round-robin arbiter and write sequencer for a shared register.
//             Optional locked bursts are compiled in with DFF_ARB_LOCK_EN.
//  Revision : 1.0
// ============================================================================
module dff_bank_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
`ifdef DFF_ARB_LOCK_EN
  input  logic [NREQ-1:0]       lock,
`endif
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic                  q_valid,
  output logic                  busy
);

  localparam int             c_PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] c_ONE  = NREQ'(1);
  localparam logic [1:0]     c_IDLE  = 2'd0;
  localparam logic [1:0]     c_GRANT = 2'd1;
  localparam logic [1:0]     c_ACK   = 2'd2;

  logic [1:0]      r_state;
  logic [c_PW-1:0] r_ptr;
  logic [c_PW-1:0] r_win;
  logic [c_PW-1:0] w_win;
  logic [c_PW-1:0] w_idx;
  logic [WIDTH-1:0] w_slice [NREQ];
  logic            w_hold;

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign w_slice[i] = wdata[i*WIDTH +: WIDTH];
  end

  // Scan downward so the nearest set bit after the pointer is assigned last.
  always_comb begin
    w_win = '0;
    w_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = c_PW'((int'(r_ptr) + k) % NREQ);
      if (req[w_idx]) w_win = w_idx;
    end
  end

`ifdef DFF_ARB_LOCK_EN
  logic [3:0] r_lock_cnt;

  assign w_hold = lock[r_win] & req[r_win] & (r_lock_cnt < 4'(MAX_LOCK - 1));

  always_ff @(posedge clk) begin
    if (!areset) begin
      r_lock_cnt <= '0;
    end else if (r_state == c_ACK) begin
      r_lock_cnt <= w_hold ? r_lock_cnt + 4'd1 : 4'd0;
    end else if (r_state == c_GRANT && !req[r_win]) begin
      r_lock_cnt <= '0;
    end
  end
`else
  assign w_hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!areset) begin
      r_state <= c_IDLE;
      r_ptr   <= c_PW'(NREQ - 1);
      r_win   <= '0;
      gnt     <= '0;
      ack     <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      ack <= '0;
      case (r_state)
        c_IDLE: begin
          if (|req) begin
            r_state <= c_GRANT;
            r_win   <= w_win;
            gnt     <= c_ONE << w_win;
            busy    <= 1'b1;
          end
        end
        c_GRANT: begin
          gnt <= '0;
          if (req[r_win]) begin
            q       <= w_slice[r_win];
            ack     <= c_ONE << r_win;
            q_valid <= 1'b1;
            r_ptr   <= r_win;
            r_state <= c_ACK;
          end else begin
            // Withdrawn request: drop the grant without moving the pointer.
            r_state <= c_IDLE;
            busy    <= 1'b0;
          end
        end
        c_ACK: begin
          if (w_hold) begin
            r_state <= c_GRANT;
            gnt     <= c_ONE << r_win;
          end else begin
            r_state <= c_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= c_IDLE;
          gnt     <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dff_bank_arbiter
//  Purpose  : Scoreboard bench for dff_bank_arbiter with a transaction model.
//  Revision : 1.0
// ============================================================================
module tb_dff_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  areset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      q;
  logic                  q_valid;
  logic                  busy;
`ifdef DFF_ARB_LOCK_EN
  logic [NREQ-1:0]       lock = '0;
`endif

  dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_LOCK(4)) dut (
    .clk(clk), .areset(areset), .req(req), .wdata(wdata),
`ifdef DFF_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt), .ack(ack), .q(q), .q_valid(q_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [NREQ-1:0] oh(input int w);
    logic [NREQ-1:0] v;
    v = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  // Transaction-level reference: a write is offered when the arbiter is free,
  // commits one cycle later if still requested, and the arbiter is free again
  // two cycles after the commit.
  typedef struct { int w; logic [WIDTH-1:0] d; } exp_t;
  exp_t sb[$];

  int              phase;
  int              pend;
  int              last;
  logic [NREQ-1:0] exp_gnt;
  logic [WIDTH-1:0] exp_q;
  logic            exp_qv;
  logic            rst_seen;

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int from);
    int w;
    bit found;
    w = 0;
    found = 0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && r[(from + k) % NREQ]) begin
        w = (from + k) % NREQ;
        found = 1;
      end
    end
    return w;
  endfunction

  always @(posedge clk) begin
    if (!areset) begin
      rst_seen = 1'b1;
      phase    = 0;
      last     = NREQ - 1;
      exp_gnt  = '0;
      exp_q    = '0;
      exp_qv   = 1'b0;
      sb.delete();
    end else begin
      rst_seen = 1'b0;
      exp_gnt  = '0;
      if (phase == 0) begin
        if (req != '0) begin
          pend    = rr_pick(req, last);
          exp_gnt = oh(pend);
          phase   = 2;
        end
      end else if (phase == 2) begin
        if (req[pend]) begin
          exp_q  = wdata[pend*WIDTH +: WIDTH];
          exp_qv = 1'b1;
          last   = pend;
          sb.push_back('{w: pend, d: exp_q});
          phase  = 1;
        end else begin
          phase = 0;
        end
      end else begin
        phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_seen) begin
      chk("reset_outputs", {gnt, ack, q, q_valid, busy}, '0);
    end else begin
      chk("gnt", gnt, exp_gnt);
      chk("busy", busy, phase != 0);
      chk("q_valid", q_valid, exp_qv);
      chk("q", q, exp_q);
      if (sb.size() > 0 || ack != '0) begin
        if (sb.size() == 0) begin
          chk("ack_unexpected", ack, '0);
        end else begin
          e = sb.pop_front();
          chk("ack", ack, oh(e.w));
          chk("ack_q", q, e.d);
        end
      end
    end
  end

  logic [NREQ-1:0] drop_pend;

  task automatic agent_step(input bit allow);
    for (int i = 0; i < NREQ; i++) begin
      if (drop_pend[i]) begin
        req[i] = 1'b0;
        drop_pend[i] = 1'b0;
      end else if (ack[i]) begin
        drop_pend[i] = 1'b1;
      end else if (allow && !req[i] && $urandom_range(0, 3) == 0) begin
        req[i] = 1'b1;
        wdata[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      end
    end
  endtask

  task automatic wait_ack();
    int n;
    n = 0;
    while (ack == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ack == '0) chk("ack_timeout", 0, 1);
  endtask

  initial begin
    int n;
    areset = 1'b0;
    req    = '0;
    wdata  = '0;
    drop_pend = '0;
    for (int i = 0; i < NREQ; i++) wdata[i*WIDTH +: WIDTH] = WIDTH'(8'h10 + i);

    // Reset held with all requests high, then rotation with all held high.
    @(negedge clk);
    req = '1;
    repeat (2) @(negedge clk);
    chk("rst_q", q, 8'h00);
    areset = 1'b1;
    @(negedge clk);
    chk("first_gnt", gnt, 4'b0001);
    repeat (15) @(negedge clk);
    req = '0;
    repeat (4) @(negedge clk);

    // Single write from requester 2.
    req = 4'b0100;
    wdata[2*WIDTH +: WIDTH] = 8'hA5;
    wait_ack();
    chk("single_ack", ack, 4'b0100);
    chk("single_q", q, 8'hA5);
    @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);
    chk("single_hold", q, 8'hA5);

    // Requester 0 writes so the pointer rests on 0.
    req = 4'b0001;
    wdata[0 +: WIDTH] = 8'h5A;
    wait_ack();
    chk("r0_ack", ack, 4'b0001);
    @(negedge clk);
    req = '0;
    repeat (2) @(negedge clk);

    // Abort: requester 1 withdraws during its grant.
    req = 4'b0010;
    wdata[WIDTH +: WIDTH] = 8'hBB;
    @(negedge clk);
    chk("abort_gnt", gnt, 4'b0010);
    req = '0;
    @(negedge clk);
    chk("abort_noack", ack, 4'b0000);
    chk("abort_q", q, 8'h5A);
    req = 4'b0011;
    wdata[0 +: WIDTH] = 8'hC0;
    wdata[WIDTH +: WIDTH] = 8'hC1;
    wait_ack();
    chk("abort_next", ack, 4'b0010);
    @(negedge clk);
    req = 4'b0001;
    wait_ack();
    chk("abort_then0", ack, 4'b0001);
    @(negedge clk);
    req = '0;
    repeat (2) @(negedge clk);

    // Reset during the grant cycle.
    req = 4'b1000;
    wdata[3*WIDTH +: WIDTH] = 8'h77;
    n = 0;
    while (gnt == '0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("mid_gnt_seen", gnt, 4'b1000);
    areset = 1'b0;
    req = '0;
    @(negedge clk);
    chk("mid_q", q, 8'h00);
    chk("mid_ack", ack, 4'b0000);
    chk("mid_qv", q_valid, 1'b0);
    areset = 1'b1;
    @(negedge clk);

    // Randomized protocol-compliant requesters, then drain.
    repeat (600) begin
      @(negedge clk);
      agent_step(1'b1);
    end
    repeat (30) begin
      @(negedge clk);
      agent_step(1'b0);
    end
    chk("drain_sb", sb.size(), 0);
    chk("drain_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin arbiter and write sequencer for one shared WIDTH-bit D-flip-flop register bank.
- NREQ requesters compete for write access to the register.
- The block grants one requester at a time, captures that requester's data into the register, and returns a one-cycle acknowledge.
- It sits between requester logic and the shared register, and it owns the register's d/enable sequencing.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, register data width in bits.
- MAX_LOCK, 4, maximum consecutive writes by one requester when locking is compiled in (1..15).

Ports:
- clk  input  1  rising-edge clock for all state.
- areset  input  1  synchronous, active-low reset; sampled on the rising clk edge.
- req  input  NREQ  per-requester write request; must stay high until that requester's ack.
- wdata  input  NREQ*WIDTH  write data; slice i is bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot registered grant; all zero when no grant is active.
- ack  output  NREQ  one-cycle pulse marking that requester's write as committed.
- q  output  WIDTH  shared register contents.
- q_valid  output  1  high once any write has completed since reset.
- busy  output  1  high whenever the state is not IDLE.
- lock  input  NREQ  present only with DFF_ARB_LOCK_EN; per-requester hold request.

Behaviour:
- Reset (areset==0 at a clk edge):
  - state=IDLE; gnt=0, ack=0, q=0, q_valid=0, busy=0.
  - ptr=NREQ-1, so requester 0 has first priority.
  - lock_cnt=0.
  - Reset overrides any in-flight transfer: no ack, and q is forced to 0.
- FSM states: IDLE, GRANT, ACK. All outputs are registered.
- IDLE:
  - If req!=0, the winner w is the first set bit searching upward from ptr+1, wrapping modulo NREQ.
  - Next state is GRANT with gnt=1<<w.
  - If req==0, the block stays in IDLE.
- GRANT (one cycle):
  - If req[w]==1: q <= wdata[w] at the closing edge; next state ACK; gnt cleared; ack[w]=1; q_valid=1; ptr <= w.
  - If req[w]==0 (requester withdrew): abort to IDLE; gnt cleared; no ack; q unchanged; ptr unchanged.
- ACK (one cycle): ack[w] is high for exactly this cycle, then next state is IDLE.
  - Requesters drop req[w] in the cycle after seeing ack.
  - Arbitration in IDLE samples req one cycle after ACK, so a req still high then is treated as a new request.
- Latency:
  - A req first seen high in IDLE at edge T gives gnt at T+1, q updated and ack at T+2, and IDLE at T+3.
  - Minimum spacing between writes is 3 cycles.
- Round-robin:
  - With all req lines held high, grants rotate 0,1,2,3,0...
  - The pointer wraps from NREQ-1 to 0.
  - An aborted grant does not advance the pointer.
- Changes to req during GRANT by non-winners are ignored until the next IDLE.
- wdata of non-granted requesters never affects q.

Optional Feature:
- Macro: DFF_ARB_LOCK_EN.
- With the macro defined:
  - The lock port exists.
  - In ACK, if lock[w]==1, req[w]==1 and lock_cnt<MAX_LOCK-1, next state is GRANT with the same w (no re-arbitration), gnt=1<<w, and lock_cnt increments.
  - Otherwise the block goes to IDLE and lock_cnt clears.
  - Locked bursts therefore write every 2 cycles and are capped at MAX_LOCK writes before forced release to round-robin.
- Without the macro: the lock port is absent, ACK always goes to IDLE, and lock_cnt is not implemented.

Test Plan:
- Reset: hold areset=0 for 2 cycles with req=4'b1111 -> gnt=0, ack=0, q=8'h00, q_valid=0, busy=0 throughout; release, then first gnt=4'b0001 two edges after release.
- Single write: req=4'b0100, wdata[2]=8'hA5 -> gnt=4'b0100 at T+1, q=8'hA5 and ack=4'b0100 at T+2, IDLE at T+3; q holds 8'hA5 afterwards.
- Fairness: req=4'b1111 continuously, slice i data=8'h10+i -> ack order 0,1,2,3,0; q sequence 10,11,12,13,10, one write every 3 cycles.
- Abort: req=4'b0010 raised, then dropped during GRANT -> no ack, q unchanged; next request with req=4'b0011 is granted to 1 first, because the pointer did not advance.
- Reset mid-transfer: areset=0 during the GRANT cycle -> next cycle gnt=0, ack=0, q=8'h00, q_valid=0.
- With DFF_ARB_LOCK_EN: req=4'b0011, lock=4'b0001, MAX_LOCK=4 -> four consecutive acks to requester 0 at 2-cycle spacing, then IDLE, then requester 1 granted.
